// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder on the data-memory bus, alongside the data RAM.
// It claims eight words starting at BASE_ADDR. Reads are registered with the
// same one-cycle latency as the RAM.
//
// Register map (word offsets):
//   0 LED        RW  [15:0]  drives led_out
//   1 BTN_LEVEL  RO          debounced button levels
//   2 BTN_PRESS  RW1C        rising-edge flags of the debounced levels
//   3 CYCLES     RO          free-running cycle counter
//   4 TLOAD      RW          timer reload value; a write also loads TCOUNT
//   5 TCTRL      bit0 EN, bit1 AUTO, bit2 EXP (RW1C)
//   6 TCOUNT     RO          timer down-counter
//   7 reserved   reads 0
//
// Ports:
//   clock, reset (async active-low)
//   wren, address_dmem, data    processor store strobe, word address, store data
//   q_mmio, hit_q               registered read data and window-hit flag
//   btn_in                      raw asynchronous buttons
//   led_out                     LED register
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wren,
  input  logic [31:0]        address_dmem,
  input  logic [31:0]        data,
  output logic [31:0]        q_mmio,
  output logic               hit_q,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [15:0]        led_out
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Decode
  logic       hit_c;
  logic [2:0] off_c;
  logic       wr_c;
  logic       wr_led_c, wr_press_c, wr_tload_c, wr_tctrl_c;

  assign hit_c      = (address_dmem[31:3] == BASE_ADDR[31:3]);
  assign off_c      = address_dmem[2:0];
  assign wr_c       = wren & hit_c;
  assign wr_led_c   = wr_c & (off_c == 3'd0);
  assign wr_press_c = wr_c & (off_c == 3'd2);
  assign wr_tload_c = wr_c & (off_c == 3'd4);
  assign wr_tctrl_c = wr_c & (off_c == 3'd5);

  // State
  logic [31:0]                   rdata_q, rdata_c;
  logic [15:0]                   led_q;
  logic [NUM_BTN-1:0]            sync1_q, sync2_q;
  logic [NUM_BTN-1:0]            level_q, level_d;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_BTN-1:0]            press_q, press_d;
  logic [NUM_BTN-1:0]            rise_c;
  logic [31:0]                   cycles_q;
  logic [31:0]                   tload_q;
  logic [31:0]                   tcount_q, tcount_d;
  logic                          en_q, auto_q, exp_q, exp_d;
  logic                          expire_c;

  // Read mux over pre-write register values
  always_comb begin
    rdata_c = '0;
    if (hit_c) begin
      case (off_c)
        3'd0:    rdata_c = {16'h0000, led_q};
        3'd1:    rdata_c = 32'(level_q);
        3'd2:    rdata_c = 32'(press_q);
        3'd3:    rdata_c = cycles_q;
        3'd4:    rdata_c = tload_q;
        3'd5:    rdata_c = {29'd0, exp_q, auto_q, en_q};
        3'd6:    rdata_c = tcount_q;
        default: rdata_c = '0;
      endcase
    end
  end

  // Debounce: level flips once the synchronized input has differed for
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise_c = level_d & ~level_q;

  // Press flags: hardware set wins over software clear
  always_comb begin
    press_d = (press_q & ~(wr_press_c ? data[NUM_BTN-1:0] : '0)) | rise_c;
  end

  // Timer: expiry is the 1->0 step; AUTO replaces that step with a reload.
  // A TLOAD write overrides whatever the counter would otherwise do.
  assign expire_c = en_q & (tcount_q == 32'd1);

  always_comb begin
    tcount_d = tcount_q;
    if (en_q && (tcount_q != 32'd0)) begin
      tcount_d = (expire_c && auto_q) ? tload_q : (tcount_q - 32'd1);
    end
    if (wr_tload_c) begin
      tcount_d = data;
    end
    exp_d = expire_c | (exp_q & ~(wr_tctrl_c & data[2]));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q  <= '0;
      hit_q    <= 1'b0;
      led_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      press_q  <= '0;
      cycles_q <= '0;
      tload_q  <= '0;
      tcount_q <= '0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_c;
      hit_q    <= hit_c;
      sync1_q  <= btn_in;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      cycles_q <= cycles_q + 32'd1;
      tcount_q <= tcount_d;
      exp_q    <= exp_d;
      if (wr_led_c) begin
        led_q <= data[15:0];
      end
      if (wr_tload_c) begin
        tload_q <= data;
      end
      if (wr_tctrl_c) begin
        en_q   <= data[0];
        auto_q <= data[1];
      end
    end
  end

  assign q_mmio  = rdata_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed register/timer/debounce
// scenarios with literal expectations, then randomized bus and button traffic
// checked every cycle against a behavioural model.
module tb_mmio_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int NB = 4;
  localparam int DC = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wren = 1'b0;
  logic [31:0]   address_dmem = '0;
  logic [31:0]   data = '0;
  logic [31:0]   q_mmio;
  logic          hit_q;
  logic [NB-1:0] btn_in = '0;
  logic [15:0]   led_out;

  int n_checks = 0;
  int n_errors = 0;

  mmio_responder #(
    .BASE_ADDR      (BASE),
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wren        (wren),
    .address_dmem(address_dmem),
    .data        (data),
    .q_mmio      (q_mmio),
    .hit_q       (hit_q),
    .btn_in      (btn_in),
    .led_out     (led_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]   m_q;
  logic          m_hit;
  logic [15:0]   m_led;
  logic [NB-1:0] m_level, m_press;
  logic [31:0]   m_cycles, m_tload, m_tcount;
  logic          m_en, m_auto, m_exp;
  logic [NB-1:0] m_hist [0:DC+1];   // raw button samples, [0] = newest edge

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return {16'h0, m_led};
      3'd1:    return {28'h0, m_level};
      3'd2:    return {28'h0, m_press};
      3'd3:    return m_cycles;
      3'd4:    return m_tload;
      3'd5:    return {29'h0, m_exp, m_auto, m_en};
      3'd6:    return m_tcount;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic          hit, wr, expire;
    logic [2:0]    off;
    logic [NB-1:0] rise, clr;
    logic [31:0]   tc_next;
    bit            all_diff;
    hit = ((address_dmem >> 3) == (BASE >> 3));
    off = address_dmem[2:0];
    wr  = wren && hit;
    m_q   = hit ? model_read(off) : 32'h0;
    m_hit = hit;
    // A button's synchronized value seen at this edge is the raw sample from
    // two edges ago; the level flips when DC such values all disagree with it.
    for (int k = DC + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = btn_in;
    rise = '0;
    for (int b = 0; b < NB; b++) begin
      all_diff = 1'b1;
      for (int k = 2; k <= DC + 1; k++)
        if (m_hist[k][b] == m_level[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[b] = ~m_level[b];
        if (m_level[b]) rise[b] = 1'b1;
      end
    end
    clr = (wr && off == 3'd2) ? data[NB-1:0] : '0;
    m_press = (m_press & ~clr) | rise;
    if (wr && off == 3'd0) m_led = data[15:0];
    m_cycles = m_cycles + 1;
    expire  = m_en && (m_tcount == 1);
    tc_next = m_tcount;
    if (m_en && m_tcount != 0) tc_next = (expire && m_auto) ? m_tload : m_tcount - 1;
    if (wr && off == 3'd4) begin
      m_tload = data;
      tc_next = data;
    end
    m_tcount = tc_next;
    m_exp = expire || (m_exp && !(wr && off == 3'd5 && data[2]));
    if (wr && off == 3'd5) begin
      m_en   = data[0];
      m_auto = data[1];
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q = 0; m_hit = 0; m_led = 0; m_level = 0; m_press = 0;
      m_cycles = 0; m_tload = 0; m_tcount = 0; m_en = 0; m_auto = 0; m_exp = 0;
      for (int k = 0; k <= DC + 1; k++) m_hist[k] = '0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    chk("q_mmio", q_mmio, m_q);
    chk("hit_q", {31'h0, hit_q}, {31'h0, m_hit});
    chk("led_out", {16'h0, led_out}, {16'h0, m_led});
  end

  // ---------------- stimulus ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    address_dmem = a;
    data = d;
    wren = 1'b1;
    @(negedge clock);
    wren = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] v);
    address_dmem = a;
    data = $urandom;
    wren = 1'b0;
    @(negedge clock);
    v = q_mmio;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] exp_seq [5];
    int r;

    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_q", q_mmio, 32'h0);
    chk("rst_hit", {31'h0, hit_q}, 32'h0);
    chk("rst_led", {16'h0, led_out}, 32'h0);
    #2 reset = 1'b1;
    @(negedge clock);

    // LED write and readback
    do_write(32'h1000, 32'hFFFF_A5C3);
    chk("led_write", {16'h0, led_out}, 32'h0000_A5C3);
    do_read(32'h1000, v);
    chk("led_read", v, 32'h0000_A5C3);
    chk("led_read_hit", {31'h0, hit_q}, 32'h1);

    // Window miss
    do_read(32'h1008, v);
    chk("miss_q", v, 32'h0);
    chk("miss_hit", {31'h0, hit_q}, 32'h0);
    do_write(32'h0000_0FFF, 32'h0000_1234);
    chk("miss_led", {16'h0, led_out}, 32'h0000_A5C3);

    // Debounce: short glitch ignored, long hold accepted, W1C clear
    btn_in[0] = 1'b1;
    repeat (10) @(negedge clock);
    btn_in[0] = 1'b0;
    repeat (25) @(negedge clock);
    do_read(32'h1001, v);
    chk("glitch_level", v, 32'h0);
    do_read(32'h1002, v);
    chk("glitch_press", v, 32'h0);
    btn_in[0] = 1'b1;
    repeat (20) @(negedge clock);
    do_read(32'h1001, v);
    chk("hold_level", v, 32'h1);
    do_read(32'h1002, v);
    chk("hold_press", v, 32'h1);
    do_write(32'h1002, 32'h1);
    do_read(32'h1002, v);
    chk("press_clear", v, 32'h0);
    btn_in[0] = 1'b0;
    repeat (25) @(negedge clock);

    // Timer one-shot: EXP visible five edges after EN
    do_write(32'h1004, 32'd5);
    do_write(32'h1005, 32'h1);
    for (int i = 0; i < 6; i++) begin
      do_read(32'h1005, v);
      chk("oneshot_tctrl", v, (i == 5) ? 32'h5 : 32'h1);
    end
    do_read(32'h1006, v);
    chk("oneshot_tcount0", v, 32'h0);
    do_read(32'h1006, v);
    chk("oneshot_tcount_hold", v, 32'h0);
    do_write(32'h1005, 32'h5);
    do_read(32'h1005, v);
    chk("oneshot_exp_clear", v, 32'h1);

    // Timer autoreload and set/clear collision at expiry
    do_write(32'h1005, 32'h0);
    do_write(32'h1004, 32'd3);
    do_write(32'h1005, 32'h3);
    exp_seq = '{32'd3, 32'd2, 32'd1, 32'd3, 32'd2};
    for (int i = 0; i < 5; i++) begin
      do_read(32'h1006, v);
      chk("auto_tcount", v, exp_seq[i]);
    end
    do_write(32'h1005, 32'h7);
    do_read(32'h1005, v);
    chk("auto_collision", v, 32'h7);
    do_write(32'h1005, 32'h4);
    do_read(32'h1005, v);
    chk("auto_stop", v, 32'h0);

    // Asynchronous reset between edges
    do_write(32'h1000, 32'h0000_00FF);
    do_read(32'h1003, v);
    chk("cycles_gt100", {31'h0, v > 32'd100}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("async_led", {16'h0, led_out}, 32'h0);
    chk("async_q", q_mmio, 32'h0);
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    chk("post_rst_cycles0", q_mmio, 32'h0);
    @(negedge clock);
    chk("post_rst_cycles1", q_mmio, 32'h1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 7));
      if (r < 6)       address_dmem = BASE | 32'($urandom_range(0, 7));
      else if (r == 6) address_dmem = ($urandom_range(0, 1) != 0) ? 32'h0000_0FFF : 32'h0000_1008;
      else             address_dmem = $urandom;
      wren = ($urandom_range(0, 2) == 0);
      data = (address_dmem[2:0] == 3'd4) ? 32'($urandom_range(0, 12)) : $urandom;
      if ($urandom_range(0, 15) == 0)
        btn_in = btn_in ^ (NB'(1) << $urandom_range(0, NB - 1));
      if ($urandom_range(0, 699) == 0) begin
        #2 reset = 1'b0;
        #6 reset = 1'b1;
      end
      @(negedge clock);
    end
    wren = 1'b0;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Responder on the processor's data-memory bus, in parallel with the data RAM. It claims a small address window and serves memory-mapped I/O registers: LED output, debounced buttons with press flags, a free-running cycle counter and a down-counting timer.
- The processor's lw/sw to this window read and write these registers instead of RAM.
- Top-level muxing selects q_mmio over RAM dataOut when hit_q is high.

Parameters:
- BASE_ADDR, 32'h0000_1000: word address of register 0. The window is BASE_ADDR[31:3] with 8 word registers.
- NUM_BTN, 4: number of button inputs. Range 1..16.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed to change a debounced level. Minimum 1.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- wren, input, 1: processor store strobe.
- address_dmem, input, 32: processor data word address.
- data, input, 32: processor store data.
- q_mmio, output, 32: registered read data.
- hit_q, output, 1: registered; high when the previous cycle's address was in the window.
- btn_in, input, NUM_BTN: raw asynchronous buttons.
- led_out, output, 16: LED register.

Behaviour:
- Decode: hit = (address_dmem[31:3] == BASE_ADDR[31:3]). Offset = address_dmem[2:0].
- Writes take effect at the rising edge where wren & hit. A write outside the window has no effect.
- Reads: q_mmio and hit_q register on every rising edge. Read latency is 1 cycle, matching the RAM. When not hit, q_mmio = 0.
- Reads return pre-write register values when a read and a write target the same register in the same cycle.
- Register map (unused bits read 0):
  - 0 LED, RW, [15:0]. Drives led_out.
  - 1 BTN_LEVEL, RO: debounced levels.
  - 2 BTN_PRESS, RW1C. A bit sets on a debounced 0->1 transition; writing 1 clears it. If set and clear coincide, set wins.
  - 3 CYCLES, RO: 32-bit free-running counter, +1 every cycle, wraps 0xFFFFFFFF->0.
  - 4 TLOAD, RW, 32 bits. A write also loads TCOUNT with the same value and clears nothing else.
  - 5 TCTRL: bit0 EN (RW), bit1 AUTO (RW), bit2 EXP (RW1C, set by hardware). A write of bit2=1 clears EXP unless an expiry occurs that same cycle; set wins.
  - 6 TCOUNT, RO.
  - 7 reserved: reads 0, writes ignored.
- Debounce, per button:
  - 2-flop synchronizer, then a counter.
  - If the synchronized input differs from the debounced level, the counter increments, otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the level flips next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the level.
  - Press latency from raw edge: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles.
- Timer:
  - When EN=1 and TCOUNT!=0, TCOUNT decrements each cycle.
  - On the 1->0 transition, EXP sets. If AUTO=1, TCOUNT reloads with TLOAD instead of becoming 0; the reload cycle is the expiry cycle.
  - EN=0 freezes TCOUNT.
  - TCOUNT=0 with EN=1 and AUTO=1 stays 0 and does not set EXP.
  - A TLOAD write in the same cycle as a decrement wins: TCOUNT = written value.
- Reset (reset=0, asynchronous), all of the following clear immediately regardless of the clock:
  - q_mmio=0, hit_q=0, led_out=0, LED=0.
  - BTN_LEVEL=0, BTN_PRESS=0, synchronizers and debounce counters=0.
  - CYCLES=0, TLOAD=0, TCOUNT=0, TCTRL=0.
- Reset deassertion mid-operation: behaviour resumes from the reset state. Pending presses are lost.

Test Plan:
- Write LED: wren=1, addr=0x1000, data=0xFFFF_A5C3 -> led_out=0xA5C3 after the edge. Read 0x1000 -> q_mmio=0x0000_A5C3 and hit_q=1, one cycle later.
- Window miss: read 0x1008, and write to 0x0FFF -> hit_q=0, q_mmio=0, LED unchanged.
- Debounce (DEBOUNCE_CYCLES=16):
  - btn_in[0] pulsed high 10 cycles -> BTN_LEVEL stays 0, BTN_PRESS=0.
  - Held high 20 cycles -> BTN_LEVEL[0]=1, BTN_PRESS[0]=1.
  - Write 0x1 to 0x1002 -> BTN_PRESS reads 0.
- Timer one-shot: TLOAD=5, TCTRL=0x1 -> EXP=1 exactly 5 cycles after EN is set, TCOUNT=0 and held there.
  - Write TCTRL=0x5 -> EXP cleared, EN stays 1.
- Timer autoreload: TLOAD=3, TCTRL=0x3 -> EXP sets and TCOUNT reloads to 3 every 3 cycles, sequence 3,2,1,3,2,1. Set/clear collision at expiry -> EXP remains 1.
- Async reset: assert reset=0 between clock edges with LED=0x00FF and CYCLES>100 -> led_out=0 and q_mmio=0 immediately. CYCLES reads 1 one cycle after release plus read latency.
